// File: rtl/game_defs.sv
// Shared game definitions: state encodings, speed limit and BCD helpers.
package game_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } gameState_t;

    localparam int unsigned SPEED_MAX = 7;
    localparam logic [15:0] BCD_MAX   = 16'h9999;

    // 4-digit BCD increment with ripple carry, saturating at 9999.
    function automatic logic [15:0] bcdInc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != BCD_MAX) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises an asynchronous active-low button and accepts a new level
// only after it has been stable for DEBOUNCE_CYCLES cycles.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] stableCnt;

    // Counter tracks consecutive cycles the synchronised input differs from level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync      <= 2'b11;
            stableCnt <= '0;
            level     <= 1'b1;
        end else begin
            sync <= {sync[0], btn};
            if (sync[1] == level) begin
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                level     <= sync[1];
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game-flow controller downstream of gameBrain: run/pause/over FSM,
// BCD score and high score, and difficulty speed.
module score_keeper #(
    parameter int unsigned DEBOUNCE_CYCLES  = 500000,
    parameter int unsigned APPLES_PER_LEVEL = 5,
    parameter int unsigned SPEED_INIT       = 1,
    parameter int unsigned SPEED_MAX        = game_defs::SPEED_MAX
) (
    input  logic        master_clk,
    input  logic        rst,
    input  logic        startBtn,
    input  logic        pauseBtn,
    input  logic        hitApple,
    input  logic        gameOverFlag,
    output logic        startGame,
    output logic        gameRst_n,
    output logic [2:0]  Speed,
    output logic [15:0] score,
    output logic [15:0] hiScore,
    output logic [1:0]  gameState
);

    import game_defs::*;

    localparam int unsigned APPLE_W = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;
    localparam logic [APPLE_W-1:0] APPLE_LAST = APPLE_W'(APPLES_PER_LEVEL - 1);

    logic [1:0] hitSync;
    logic       hitPrev;
    logic [1:0] overSync;
    logic       startLvl, pauseLvl;
    logic       startLvlPrev, pauseLvlPrev;
    logic       hitPulse, startPress, pausePress;

    gameState_t         state, stateNext;
    logic [15:0]        scoreNext, hiNext;
    logic [2:0]         speedNext;
    logic [APPLE_W-1:0] appleCnt, appleNext;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_startDb (
        .clk   (master_clk),
        .rst   (rst),
        .btn   (startBtn),
        .level (startLvl)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pauseDb (
        .clk   (master_clk),
        .rst   (rst),
        .btn   (pauseBtn),
        .level (pauseLvl)
    );

    // Cross-domain synchronisers and edge-detect history; run in every state.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            hitSync      <= 2'b00;
            hitPrev      <= 1'b0;
            overSync     <= 2'b00;
            startLvlPrev <= 1'b1;
            pauseLvlPrev <= 1'b1;
        end else begin
            hitSync      <= {hitSync[0], hitApple};
            hitPrev      <= hitSync[1];
            overSync     <= {overSync[0], gameOverFlag};
            startLvlPrev <= startLvl;
            pauseLvlPrev <= pauseLvl;
        end
    end

    assign hitPulse   = hitSync[1] & ~hitPrev;
    assign startPress = startLvlPrev & ~startLvl;
    assign pausePress = pauseLvlPrev & ~pauseLvl;

    always_comb begin
        stateNext = state;
        scoreNext = score;
        hiNext    = hiScore;
        speedNext = Speed;
        appleNext = appleCnt;
        case (state)
            IDLE: begin
                if (startPress) begin
                    stateNext = RUN;
                    scoreNext = 16'h0000;
                    appleNext = '0;
                    speedNext = 3'(SPEED_INIT);
                end
            end
            RUN: begin
                if (hitPulse) begin
                    scoreNext = bcdInc(score);
                    if (appleCnt == APPLE_LAST) begin
                        appleNext = '0;
                        if (Speed < 3'(SPEED_MAX)) begin
                            speedNext = Speed + 3'd1;
                        end
                    end else begin
                        appleNext = appleCnt + APPLE_W'(1);
                    end
                end
                // Game over wins over a simultaneous pause; final hit is included.
                if (overSync[1]) begin
                    stateNext = OVER;
                    if (scoreNext > hiScore) begin
                        hiNext = scoreNext;
                    end
                end else if (pausePress) begin
                    stateNext = PAUSE;
                end
            end
            PAUSE: begin
                if (pausePress) begin
                    stateNext = RUN;
                end
            end
            OVER: begin
                if (startPress) begin
                    stateNext = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            score     <= 16'h0000;
            hiScore   <= 16'h0000;
            Speed     <= 3'(SPEED_INIT);
            appleCnt  <= '0;
            startGame <= 1'b0;
            gameRst_n <= 1'b0;
        end else begin
            state     <= stateNext;
            score     <= scoreNext;
            hiScore   <= hiNext;
            Speed     <= speedNext;
            appleCnt  <= appleNext;
            startGame <= (stateNext == RUN);
            gameRst_n <= (stateNext != IDLE);
        end
    end

    assign gameState = state;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: cycle-level reference model plus
// directed scenarios and randomized play.
module tb_score_keeper;

    localparam int unsigned DB = 4;

    logic        master_clk = 1'b0;
    logic        rst = 1'b0;
    logic        startBtn = 1'b1;
    logic        pauseBtn = 1'b1;
    logic        hitApple = 1'b0;
    logic        gameOverFlag = 1'b0;
    logic        startGame;
    logic        gameRst_n;
    logic [2:0]  Speed;
    logic [15:0] score;
    logic [15:0] hiScore;
    logic [1:0]  gameState;

    int passCnt = 0;
    int checkCnt = 0;

    always #5 master_clk = ~master_clk;

    score_keeper #(
        .DEBOUNCE_CYCLES  (DB),
        .APPLES_PER_LEVEL (5),
        .SPEED_INIT       (1),
        .SPEED_MAX        (7)
    ) dut (
        .master_clk   (master_clk),
        .rst          (rst),
        .startBtn     (startBtn),
        .pauseBtn     (pauseBtn),
        .hitApple     (hitApple),
        .gameOverFlag (gameOverFlag),
        .startGame    (startGame),
        .gameRst_n    (gameRst_n),
        .Speed        (Speed),
        .score        (score),
        .hiScore      (hiScore),
        .gameState    (gameState)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Inputs are sampled each rising edge; hist[k] is the sample k edges ago.
    int mSt, mScore, mHi, mSpeed, mApples;
    int hH[8], hG[8], hS[8], hP[8];
    int lvlS, lvlP, fellS, fellP;

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // True when the button has read v for the last DB synchronised samples.
    function automatic bit windowAll(input int h[8], input int v);
        for (int k = 2; k <= int'(DB) + 1; k++) if (h[k] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            hH[i] = 0; hG[i] = 0; hS[i] = 1; hP[i] = 1;
        end
        lvlS = 1; lvlP = 1; fellS = 0; fellP = 0;
        mSt = 0; mScore = 0; mHi = 0; mSpeed = 1; mApples = 0;
    endtask

    task automatic modelStep();
        bit hp, ov, sp, pp;
        for (int i = 7; i > 0; i--) begin
            hH[i] = hH[i-1]; hG[i] = hG[i-1]; hS[i] = hS[i-1]; hP[i] = hP[i-1];
        end
        hH[0] = int'(hitApple); hG[0] = int'(gameOverFlag);
        hS[0] = int'(startBtn); hP[0] = int'(pauseBtn);
        hp = (hH[2] == 1) && (hH[3] == 0);
        ov = (hG[2] == 1);
        sp = (fellS == 1);
        pp = (fellP == 1);
        fellS = 0;
        if (windowAll(hS, 1 - lvlS)) begin fellS = lvlS; lvlS = 1 - lvlS; end
        fellP = 0;
        if (windowAll(hP, 1 - lvlP)) begin fellP = lvlP; lvlP = 1 - lvlP; end
        case (mSt)
            0: if (sp) begin mSt = 1; mScore = 0; mApples = 0; mSpeed = 1; end
            1: begin
                if (hp) begin
                    if (mScore < 9999) mScore++;
                    mApples++;
                    if (mApples == 5) begin
                        mApples = 0;
                        if (mSpeed < 7) mSpeed++;
                    end
                end
                if (ov) begin
                    mSt = 3;
                    if (mScore > mHi) mHi = mScore;
                end else if (pp) mSt = 2;
            end
            2: if (pp) mSt = 1;
            default: if (sp) mSt = 0;
        endcase
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge master_clk);
            if (!rst) modelReset();
            else modelStep();
        end
    end

    // Every-cycle comparison against the model, sampled after the edge.
    initial begin
        @(posedge master_clk);
        forever begin
            @(posedge master_clk);
            #2;
            chk("m_state", 16'(gameState), 16'(mSt));
            chk("m_startGame", 16'(startGame), 16'(mSt == 1));
            chk("m_gameRst_n", 16'(gameRst_n), 16'(mSt != 0));
            chk("m_speed", 16'(Speed), 16'(mSpeed));
            chk("m_score", score, toBcd(mScore));
            chk("m_hiScore", hiScore, toBcd(mHi));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge master_clk);
    endtask

    task automatic press(input bit isStart);
        if (isStart) startBtn = 1'b0; else pauseBtn = 1'b0;
        idle(DB + 4);
        if (isStart) startBtn = 1'b1; else pauseBtn = 1'b1;
        idle(DB + 4);
    endtask

    task automatic glitch(input bit isStart, input int len);
        if (isStart) startBtn = 1'b0; else pauseBtn = 1'b0;
        idle(len);
        if (isStart) startBtn = 1'b1; else pauseBtn = 1'b1;
        idle(DB + 2);
    endtask

    task automatic hit(input int hiLen, input int loLen);
        hitApple = 1'b1;
        idle(hiLen);
        hitApple = 1'b0;
        idle(loLen);
    endtask

    initial begin
        idle(3);
        chk("rst_state", 16'(gameState), 16'd0);
        chk("rst_startGame", 16'(startGame), 16'd0);
        chk("rst_gameRst_n", 16'(gameRst_n), 16'd0);
        chk("rst_speed", 16'(Speed), 16'd1);
        chk("rst_score", score, 16'h0000);
        chk("rst_hiScore", hiScore, 16'h0000);
        rst = 1'b1;
        idle(2);

        press(1'b1);
        chk("start_state", 16'(gameState), 16'd1);
        chk("start_startGame", 16'(startGame), 16'd1);
        chk("start_gameRst_n", 16'(gameRst_n), 16'd1);
        chk("start_speed", 16'(Speed), 16'd1);
        chk("start_score", score, 16'h0000);

        repeat (7) hit(2, 2);
        idle(4);
        chk("seven_score", score, 16'h0007);

        // Game over, last hit and pause press all land on the same edge.
        pauseBtn = 1'b0;
        idle(DB);
        hitApple = 1'b1;
        gameOverFlag = 1'b1;
        idle(6);
        hitApple = 1'b0;
        pauseBtn = 1'b1;
        idle(DB + 4);
        chk("over_state", 16'(gameState), 16'd3);
        chk("over_score", score, 16'h0008);
        chk("over_hiScore", hiScore, 16'h0008);
        chk("over_startGame", 16'(startGame), 16'd0);
        press(1'b1);
        chk("back_idle_state", 16'(gameState), 16'd0);
        chk("back_idle_gameRst_n", 16'(gameRst_n), 16'd0);
        gameOverFlag = 1'b0;
        idle(4);

        press(1'b1);
        repeat (12) hit(100, 100);
        chk("twelve_score", score, 16'h0012);
        chk("twelve_speed", 16'(Speed), 16'd3);
        hit(1000, 10);
        chk("long_hit_score", score, 16'h0013);

        press(1'b0);
        chk("pause_state", 16'(gameState), 16'd2);
        chk("pause_startGame", 16'(startGame), 16'd0);
        glitch(1'b0, 2);
        chk("glitch_state", 16'(gameState), 16'd2);
        repeat (3) hit(3, 3);
        press(1'b1);
        chk("pause_hits_score", score, 16'h0013);
        press(1'b0);
        chk("resume_state", 16'(gameState), 16'd1);
        chk("resume_score", score, 16'h0013);

        // Randomized play, checked cycle by cycle against the model.
        for (int it = 0; it < 300; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 5)      hit(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            else if (op == 6) press(1'b0);
            else if (op == 7) glitch(1'b0, int'($urandom_range(1, DB - 1)));
            else if (op == 8) glitch(1'b1, int'($urandom_range(1, DB - 1)));
            else              press(1'b1);
        end
        if (mSt == 2) press(1'b0);
        gameOverFlag = 1'b1;
        idle(6);
        press(1'b1);
        gameOverFlag = 1'b0;
        idle(4);

        press(1'b1);
        repeat (30) hit(1, 1);
        idle(4);
        chk("thirty_score", score, 16'h0030);
        rst = 1'b0;
        idle(1);
        chk("midrst_state", 16'(gameState), 16'd0);
        chk("midrst_score", score, 16'h0000);
        chk("midrst_hiScore", hiScore, 16'h0000);
        chk("midrst_gameRst_n", 16'(gameRst_n), 16'd0);
        rst = 1'b1;
        idle(2);

        press(1'b1);
        repeat (9998) hit(1, 1);
        idle(4);
        chk("sat_9998", score, 16'h9998);
        hit(1, 1);
        idle(4);
        chk("sat_9999", score, 16'h9999);
        repeat (2) hit(1, 1);
        idle(4);
        chk("sat_hold", score, 16'h9999);
        chk("sat_speed", 16'(Speed), 16'd7);
        gameOverFlag = 1'b1;
        idle(6);
        chk("sat_over_state", 16'(gameState), 16'd3);
        chk("sat_hiScore", hiScore, 16'h9999);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-flow controller and scorer sitting directly downstream of `gameBrain`. It consumes `hitApple` and `gameOverFlag`, and turns them into:

- a BCD score and high score;
- a difficulty `Speed`;
- the `startGame` run/pause enable that drives `gameBrain`'s frame generator;
- an active-low reset that re-arms `gameBrain` between games.

Player start/pause pushbuttons are debounced here. The whole block runs on `master_clk`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable `master_clk` cycles required to accept a button level change (10 ms at 50 MHz).
- `APPLES_PER_LEVEL`, 5: apples per `Speed` increment.
- `SPEED_INIT`, 1: `Speed` at game start.
- `SPEED_MAX`, 7: `Speed` saturation value.

Ports:
- `master_clk`  in  1  50 MHz system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `startBtn`  in  1  active-low pushbuttonn, asynchronous.
- `pauseBtn`  in  1  active-low pushbutton, asynchronous.
- `hitApple`  in  1  from `gameBrain`, `BALL_clk` domain; a high level means one apple eaten.
- `gameOverFlag`  in  1  from `gameBrain`, `BALL_clk` domain; sticky until `gameBrain` is reset.
- `startGame`  out  1  to `gameBrain`; high only in RUN.
- `gameRst_n`  out  1  to `gameBrain.rst`; low only in IDLE.
- `Speed`  out  3  to `gameBrain`.
- `score`  out  16  4-digit BCD, digit 3 in [15:12].
- `hiScore`  out  16  4-digit BCD.
- `gameState`  out  2  current state, for display logic.

## Operation
- **States:** IDLE=0, RUN=1, PAUSE=2, OVER=3. Reset enters IDLE.
- **Synchronisation:** `hitApple` and `gameOverFlag` each pass through a 2-flop synchroniser.
  - `hitPulse` is the rising edge of synchronised `hitApple`, detected with a third flop.
  - The edge flop updates in every state, so a `hitApple` held high across PAUSE is counted once only.
- **Buttons:** each passes through a 2-flop synchroniser, then `button_debounce`.
  - A press is a one-cycle pulse produced when the debounced level goes 1→0.
- **Transitions:**
  - IDLE + start press → RUN. On that edge: `score`←0, apple counter←0, `Speed`←`SPEED_INIT`.
  - RUN + synced `gameOverFlag`=1 → OVER. Takes priority over a pause press on the same cycle.
  - RUN + pause press → PAUSE.
  - PAUSE + pause press → RUN. Start presses are ignored in PAUSE.
  - OVER + start press → IDLE.
  - All other presses are ignored.
- **Scoring (RUN only):** each `hitPulse` adds 1 to `score` as a BCD ripple.
  - Each digit rolls 9→0 and carries into the next.
  - `score` saturates at 9999.
  - A `hitPulse` in the same cycle as the RUN→OVER transition is still counted.
- **Level:** the apple counter runs 0..`APPLES_PER_LEVEL`-1 and increments on each counted `hitPulse`.
  - On wrap it returns to 0 and `Speed` is incremented, saturating at `SPEED_MAX`.
  - `Speed` holds through PAUSE and OVER.
- **High score:** on the cycle OVER is entered, if the final `score` (including any same-cycle hit) > `hiScore`, copy it to `hiScore`.
  - Comparison is a 16-bit unsigned compare, which is valid for BCD.
  - `hiScore` is cleared only by `rst`.
- **Output decode:** `startGame`=(state==RUN) and `gameRst_n`=(state!=IDLE).
  - Holding `gameBrain` reset through IDLE clears its sticky `gameOverFlag` before the next game.

## Timing
- All outputs are registered.
- Reset values: `startGame`=0, `gameRst_n`=0, `Speed`=`SPEED_INIT`, `score`=0x0000, `hiScore`=0x0000, `gameState`=0. Synchronisers and debouncers reset to released/low.
- Reset asserted mid-game returns to IDLE immediately. The scores are cleared.
- `hitApple` rising → `score` updates on the 3rd `master_clk` rising edge.
- `gameOverFlag` rising → `gameState`=OVER and `startGame`=0 on the 3rd edge.
- Button falling (held) → state change on edge 2+`DEBOUNCE_CYCLES`+1.
- Debouncer rules:
  - A stability counter resets on any level mismatch.
  - The level is accepted when the counter reaches `DEBOUNCE_CYCLES`-1.
  - Glitches shorter than `DEBOUNCE_CYCLES` produce no press.
  - A release must also be debounced before the next press is accepted.

## Structure
- Shared header `game_defs` holds:
  - state encodings IDLE/RUN/PAUSE/OVER;
  - `SPEED_MAX`;
  - the BCD max constant 16'h9999.
- One sub-module, `button_debounce` (clk, rst, async in, debounced level out), instantiated twice. It contains its own 2-flop synchroniser and stability counter.
- FSM, BCD counter, level counter and high-score logic stay in `score_keeper`.

## Test plan
- Reset, then a start press with `DEBOUNCE_CYCLES`=4 → `gameState`=1, `startGame`=1, `gameRst_n`=1, `Speed`=1, `score`=0x0000.
- RUN; apply 12 `hitApple` pulses, each held 100 cycles → `score`=0x0012, `Speed`=3. A `hitApple` held for 1000 cycles counts once.
- RUN, then preload 9998 via 9998 hits (or force); apply 3 hits → `score` goes 0x9999 and stays 0x9999.
- RUN with `score`=0x0007; raise `gameOverFlag` together with a final `hitApple` and a pause press → `score`=0x0008, state OVER (not PAUSE), `hiScore`=0x0008. Then a start press → IDLE, `gameRst_n`=0.
- RUN: pause press → PAUSE, `startGame`=0. A 2-cycle `pauseBtn` glitch → no change. Pause press → RUN. `hitApple` edges during PAUSE do not change `score`.
- Assert `rst` during RUN with `score`=0x0030 → next cycle `gameState`=0, `score`=0, `hiScore`=0, `gameRst_n`=0.
